// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Consumed by fetch_unit and fetch_hold_buf.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instruction, pc+4} buffer used while IF/ID is stalled.
// Clear wins over load.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic        valid
);

  logic [63:0] data_q;
  logic [63:0] data_d;
  logic        valid_q;
  logic        valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, IF/ID feed.
// Define FETCH_HOLD_BUF_EN to buffer instructions acked under Hazard.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Hazard,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fetch_pc_plus4,
  output logic [31:0] fetch_instr,
  output logic        fetch_valid,
  output logic        if_id_flush
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  addr_q;
  logic [31:0]  addr_d;
  logic [31:0]  pc_inc;
  logic         issuing;
  logic         deliver;

  assign pc_inc  = pc_q + PC_STEP;
  assign issuing = (state_q != HOLD);
  assign deliver = ((state_q == FETCH) || (state_q == WAIT))
                   && imem_ack && !redirect_valid;

`ifdef FETCH_HOLD_BUF_EN
  logic        buf_load;
  logic        buf_clear;
  logic [63:0] buf_dout;
  logic        buf_valid;

  fetch_hold_buf u_hold_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clear (buf_clear),
    .din   ({imem_rdata, pc_inc}),
    .dout  (buf_dout),
    .valid (buf_valid)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // addr_q keeps the in-flight address so DISCARD can finish it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
`ifdef FETCH_HOLD_BUF_EN
    buf_load  = 1'b0;
    buf_clear = 1'b0;
`endif
    if (state_q == FETCH) addr_d = pc_q;
    if (redirect_valid) begin
      pc_d    = word_align(redirect_pc);
      state_d = (issuing && !imem_ack) ? DISCARD : FETCH;
`ifdef FETCH_HOLD_BUF_EN
      buf_clear = 1'b1;
`endif
    end else begin
      unique case (state_q)
        FETCH, WAIT: begin
          if (!imem_ack) begin
            state_d = WAIT;
          end else if (!Hazard) begin
            pc_d    = pc_inc;
            state_d = FETCH;
          end else begin
`ifdef FETCH_HOLD_BUF_EN
            buf_load = 1'b1;
            state_d  = HOLD;
`else
            state_d  = FETCH;
`endif
          end
        end
        HOLD: begin
`ifdef FETCH_HOLD_BUF_EN
          if (!Hazard) begin
            pc_d      = pc_inc;
            buf_clear = 1'b1;
            state_d   = FETCH;
          end
`else
          state_d = FETCH;
`endif
        end
        DISCARD: begin
          if (imem_ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req       = 1'b0;
    imem_addr      = addr_q;
    fetch_valid    = 1'b0;
    fetch_instr    = NOP_INSTR;
    fetch_pc_plus4 = pc_inc;
    if_id_flush    = 1'b0;
    if (!rst_n) begin
      fetch_pc_plus4 = RESET_PC + PC_STEP;
    end else begin
      if_id_flush = redirect_valid;
      unique case (state_q)
        FETCH: begin
          imem_req  = 1'b1;
          imem_addr = pc_q;
        end
        WAIT, DISCARD: begin
          imem_req = 1'b1;
        end
        HOLD: begin
`ifdef FETCH_HOLD_BUF_EN
          fetch_valid    = buf_valid;
          fetch_instr    = buf_dout[63:32];
          fetch_pc_plus4 = buf_dout[31:0];
`endif
        end
        default: ;
      endcase
      if (deliver && !Hazard) begin
        fetch_valid = 1'b1;
        fetch_instr = imem_rdata;
      end
      if (redirect_valid) begin
        fetch_valid = 1'b0;
        fetch_instr = NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect.
// Reference is a program-order scoreboard over a synthetic memory.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hazard = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] fetch_pc_plus4;
  logic [31:0] fetch_instr;
  logic        fetch_valid;
  logic        if_id_flush;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Hazard         (hazard),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .fetch_pc_plus4 (fetch_pc_plus4),
    .fetch_instr    (fetch_instr),
    .fetch_valid    (fetch_valid),
    .if_id_flush    (if_id_flush)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  // memory: ack after lat cycles of waiting
  logic rnd_mode = 1'b0;
  int   fixed_lat = 0;
  int   rnd_lat = 0;
  int   wcnt = 0;

  assign imem_ack = imem_req &&
    (wcnt >= (rnd_mode ? rnd_lat : fixed_lat));
  assign imem_rdata = imem_ack ? memf(imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!rst_n) begin
      wcnt <= 0;
    end else if (imem_req && !imem_ack) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
      if (imem_ack) rnd_lat <= $urandom_range(0, 3);
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_pc = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          deliveries = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic h, input logic rv,
                      input logic [31:0] rp, input int lat);
    @(posedge clk);
    #1;
    rst_n = r;
    hazard = h;
    redirect_valid = rv;
    redirect_pc = rp;
    fixed_lat = lat;
    #1;
    if (!rst_n) begin
      check("rst_req", imem_req, 0);
      check("rst_valid", fetch_valid, 0);
      check("rst_instr", fetch_instr, 0);
      check("rst_p4", fetch_pc_plus4, 32'd4);
      check("rst_flush", if_id_flush, 0);
      exp_pc = '0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("hs_req", imem_req, 1);
        check("hs_addr", imem_addr, pend_addr);
      end else if (imem_req) begin
        check("req_addr", imem_addr, exp_pc);
      end
      pend = imem_req && !imem_ack;
      pend_addr = imem_addr;
      check("flush", if_id_flush, redirect_valid);
      if (redirect_valid) begin
        check("rd_valid", fetch_valid, 0);
        exp_pc = {rp[31:2], 2'b00};
      end else if (fetch_valid) begin
        check("instr", fetch_instr, memf(exp_pc));
        check("p4", fetch_pc_plus4, exp_pc + 32'd4);
        if (!hazard) begin
          exp_pc = exp_pc + 32'd4;
          deliveries++;
        end
      end else begin
        check("nop", fetch_instr, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 0, 0, 0);
      check("zw_valid", fetch_valid, 1);
      check("zw_p4", fetch_pc_plus4, 32'(4 * k));
    end

    step(1, 0, 1, 32'h40, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, 3);
      check("dly_addr", imem_addr, 32'h40);
      check("dly_valid", fetch_valid, (k == 3));
    end
    check("dly_p4", fetch_pc_plus4, 32'h44);

    step(1, 0, 1, 32'h10, 0);
    step(1, 1, 0, 0, 0);
    check("hz_c1_valid", fetch_valid, 0);
    step(1, 1, 0, 0, 0);
`ifdef FETCH_HOLD_BUF_EN
    check("hz_c2_req", imem_req, 0);
`else
    check("hz_c2_req", imem_req, 1);
    check("hz_c2_addr", imem_addr, 32'h10);
`endif
    step(1, 0, 0, 0, 0);
`ifdef FETCH_HOLD_BUF_EN
    check("hz_c3_req", imem_req, 0);
`else
    check("hz_c3_addr", imem_addr, 32'h10);
`endif
    check("hz_c3_valid", fetch_valid, 1);
    check("hz_c3_p4", fetch_pc_plus4, 32'h14);

    step(1, 0, 1, 32'h20, 0);
    step(1, 0, 0, 0, 3);
    step(1, 0, 1, 32'h200, 3);
    check("rw_flush", if_id_flush, 1);
    step(1, 0, 0, 0, 0);
    check("rw_disc_addr", imem_addr, 32'h20);
    check("rw_disc_valid", fetch_valid, 0);
    step(1, 0, 0, 0, 0);
    check("rw_new_addr", imem_addr, 32'h200);
    check("rw_new_p4", fetch_pc_plus4, 32'h204);

    step(1, 0, 1, 32'h80, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h300, 0);
    check("rh_flush", if_id_flush, 1);
    check("rh_valid", fetch_valid, 0);
    step(1, 0, 0, 0, 0);
    check("rh_addr", imem_addr, 32'h300);
    check("rh_p4", fetch_pc_plus4, 32'h304);

    step(1, 0, 1, 32'h1003, 0);
    step(1, 0, 0, 0, 5);
    check("al_addr", imem_addr, 32'h1000);
    step(1, 0, 0, 0, 5);
    step(0, 0, 0, 0, 5);
    step(1, 0, 0, 0, 0);
    check("rw_req", imem_req, 1);
    check("rw_addr", imem_addr, 32'h0);
    check("rw_p4", fetch_pc_plus4, 32'h4);

    step(1, 0, 1, 32'hFFFF_FFFC, 0);
    step(1, 0, 0, 0, 0);
    check("wrap_p4", fetch_pc_plus4, 32'h0);
    step(1, 0, 0, 0, 0);
    check("wrap_addr", imem_addr, 32'h0);

    step(0, 0, 0, 0, 0);
    rnd_mode = 1'b1;
    deliveries = 0;
    for (int i = 0; i < 1500; i++) begin
      logic       r;
      logic       h;
      logic       rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 99) != 0);
      h  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 11) == 0);
      rp = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'hFFF);
      step(r, h, rv, rp, 0);
    end
    check("liveness", (deliveries > 200), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipeline, sitting directly upstream of the IF/ID register. Owns the program counter, issues one request at a time to instruction memory over a req/ack handshake, and presents {PC+4, instruction} to IF/ID each cycle IF/ID can accept it. Absorbs load-use stalls (`Hazard`) and branch/jump redirects, and drives the IF/ID flush.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `Hazard`  in  1  stall from hazard unit; IF/ID holds while 1.
- `redirect_valid`  in  1  taken branch/jump resolved downstream.
- `redirect_pc`  in  32  target of redirect.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  word address of request (= PC).
- `imem_ack`  in  1  request complete this cycle; may arrive same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction, valid with `imem_ack`.
- `fetch_pc_plus4`  out  32  PC+4 of presented instruction, to IF/ID `PCIn`.
- `fetch_instr`  out  32  instruction, to IF/ID `OrderIn`; 32'b0 (nop) when `fetch_valid`=0.
- `fetch_valid`  out  1  `fetch_instr` is a real instruction.
- `if_id_flush`  out  1  to IF/ID flush input.

## Operation
- State register `pc`; FSM states FETCH, WAIT, HOLD, DISCARD.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. Ack this cycle -> deliver (below); else -> WAIT.
- WAIT: `imem_req` held 1, `imem_addr` stable until `imem_ack`. Ack -> deliver.
- Deliver with `Hazard`=0: `fetch_valid`=1, `fetch_instr`=`imem_rdata`, `fetch_pc_plus4`=`pc`+4 (combinational, same cycle); `pc`<=`pc`+4; -> FETCH.
- Deliver with `Hazard`=1: handled per Configuration.
- HOLD: `imem_req`=0; outputs driven from hold buffer, `fetch_valid`=1; when `Hazard`=0, `pc`<=`pc`+4, -> FETCH.
- `redirect_valid`=1 (any state): `if_id_flush`=1 combinationally; `pc`<=`redirect_pc`; `fetch_valid`=0; hold buffer cleared. If a request is outstanding with no ack this cycle -> DISCARD; otherwise -> FETCH. `imem_addr` not changed mid-handshake.
- DISCARD: `imem_req`=1 at old address until ack; ack data dropped; -> FETCH at new `pc`. A second redirect in DISCARD overwrites `pc`.
- Redirect has priority over `Hazard` and over a same-cycle ack.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Low two bits of `redirect_pc` are forced to 0.

## Timing
- Reset (`rst_n`=0 at edge): `pc`=`RESET_PC`, state FETCH, hold buffer empty. While `rst_n`=0: `imem_req`=0, `fetch_valid`=0, `fetch_instr`=0, `fetch_pc_plus4`=`RESET_PC`+4, `if_id_flush`=0. Reset mid-WAIT abandons the request; memory shares the reset.
- Zero-wait memory: one instruction per cycle, first `fetch_valid` in first cycle after reset release.
- Redirect to first new-path request: one cycle (FETCH), plus remaining wait if DISCARD.
- `fetch_valid`=0 in every cycle without delivery; IF/ID then captures a nop.

## Configuration
- `FETCH_HOLD_BUF_EN` defined: ack while `Hazard`=1 stores {`imem_rdata`, `pc`+4} in a one-entry buffer, -> HOLD; no re-access of memory.
- Not defined: ack while `Hazard`=1 is dropped, `pc` unchanged, -> FETCH (replay same address); HOLD state unreachable, buffer absent.

## Structure
- `fetch_pkg`: state enum (FETCH, WAIT, HOLD, DISCARD), `NOP_INSTR`=32'b0, `PC_STEP`=4, default `RESET_PC`.
- Sub-module `fetch_hold_buf`: one-entry 64-bit buffer with load/clear/valid, instantiated only under `FETCH_HOLD_BUF_EN`.

## Test plan
- Reset release, zero-wait memory returning 32'h1000_0000+addr -> `fetch_pc_plus4`=4,8,12 on consecutive cycles, `fetch_valid`=1 every cycle.
- Ack delayed 3 cycles at pc=0x40 -> `imem_addr`=0x40 stable 4 cycles, single delivery with `fetch_pc_plus4`=0x44.
- `Hazard`=1 for 2 cycles over an ack at pc=0x10 -> with macro: no new `imem_req`, instruction presented when `Hazard` drops; without: re-request of 0x10.
- `redirect_valid`=1, `redirect_pc`=0x200 during WAIT at 0x20 -> `if_id_flush`=1 that cycle, 0x20 data dropped, next request at 0x200, next delivery `fetch_pc_plus4`=0x204.
- Redirect and `Hazard` same cycle in HOLD -> buffer cleared, request at target.
- `rst_n`=0 mid-WAIT -> next cycle `imem_req`=0, `pc`=`RESET_PC`; `redirect_pc`=0x1003 -> request at 0x1000.
